// File: rtl/cache_mem_arbiter.sv
// Shares one physical-memory line port between I-cache and D-cache; D-cache has fixed priority.
// Optional starvation guard for the I-cache is enabled by defining ARB_STARVE_GUARD_EN.
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int LINE_WIDTH   = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_cmd_read;
    logic                  r_cmd_write;
    logic [ADDR_WIDTH-1:0] r_cmd_addr;
    logic [LINE_WIDTH-1:0] r_cmd_wdata;
    logic                  w_grant_i;
    logic                  w_grant_d;
    logic                  w_d_req;
    logic                  w_starve_hit;

    assign w_d_req = d_pmem_read | d_pmem_write;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] r_starve_cnt;

    assign w_starve_hit = (r_starve_cnt == CW'(STARVE_LIMIT)) && i_pmem_read;

    // Cannot overflow: at the limit with I waiting, I wins instead of D.
    always_ff @(posedge clk) begin
        if (reset)
            r_starve_cnt <= '0;
        else if (w_grant_i)
            r_starve_cnt <= '0;
        else if (w_grant_d && i_pmem_read)
            r_starve_cnt <= r_starve_cnt + 1'b1;
        else if (r_state == IDLE && !i_pmem_read)
            r_starve_cnt <= '0;
    end
`else
    // Strict D-first priority: the guard never fires.
    assign w_starve_hit = (STARVE_LIMIT < 0);
`endif

    always_comb begin
        w_next      = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        i_pmem_resp = 1'b0;
        d_pmem_resp = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_d_req && !w_starve_hit) begin
                    w_grant_d = 1'b1;
                    w_next    = SERVE_D;
                end else if (i_pmem_read) begin
                    w_grant_i = 1'b1;
                    w_next    = SERVE_I;
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    i_pmem_resp = 1'b1;
                    w_next      = IDLE;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    d_pmem_resp = 1'b1;
                    w_next      = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cmd_read  <= 1'b0;
            r_cmd_write <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant_d) begin
                // Read+write together is illegal; it is served as a write.
                r_cmd_read  <= ~d_pmem_write;
                r_cmd_write <= d_pmem_write;
                r_cmd_addr  <= d_pmem_address;
                r_cmd_wdata <= d_pmem_wdata;
            end else if (w_grant_i) begin
                r_cmd_read  <= 1'b1;
                r_cmd_write <= 1'b0;
                r_cmd_addr  <= i_pmem_address;
                r_cmd_wdata <= '0;
            end
        end
    end

    assign pmem_read    = (r_state != IDLE) && r_cmd_read;
    assign pmem_write   = (r_state != IDLE) && r_cmd_write;
    assign pmem_address = r_cmd_addr;
    assign pmem_wdata   = r_cmd_wdata;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(d_pmem_read && d_pmem_write));

endmodule
